// File: rtl/spike_frame_parser.sv
// Spike frame parser: reads words from a sync FIFO, strips the FAF1/length/F1FA framing
// and streams the payload words as events through a 2-entry output buffer.
module spike_frame_parser #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned LEN_W = 10
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             fifo_empty,
    output logic             fifo_rd_en,
    input  logic [WIDTH-1:0] fifo_rd_data,
    output logic             ev_valid,
    input  logic             ev_ready,
    output logic [WIDTH-1:0] ev_data,
    output logic             ev_first,
    output logic             frame_done,
    output logic [LEN_W-1:0] frame_len,
    output logic             frame_err,
    output logic [7:0]       err_cnt,
    output logic             busy
);

    localparam logic [WIDTH-1:0] HDR = WIDTH'(16'hFAF1);
    localparam logic [WIDTH-1:0] TRL = WIDTH'(16'hF1FA);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_LEN     = 2'd1;
    localparam logic [1:0] S_PAYLOAD = 2'd2;
    localparam logic [1:0] S_TRAIL   = 2'd3;

    logic [1:0]       r_state;
    logic [1:0]       w_state_nxt;
    logic             r_pending;
    logic [1:0]       r_buf_cnt;
    logic [WIDTH-1:0] r_buf_data0;
    logic [WIDTH-1:0] r_buf_data1;
    logic             r_buf_first0;
    logic             r_buf_first1;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [LEN_W-1:0] r_frame_len;
    logic             r_frame_done;
    logic             r_frame_err;
    logic [7:0]       r_err_cnt;

    logic             w_is_hdr;
    logic             w_is_trl;
    logic             w_len_bad;
    logic [LEN_W-1:0] w_len_word;
    logic             w_last;
    logic             w_ev_first;
    logic             w_push;
    logic             w_pop;
    logic             w_done;
    logic             w_err;
    logic             w_len_ld;
    logic             w_cnt_inc;

    assign w_is_hdr   = (fifo_rd_data == HDR);
    assign w_is_trl   = (fifo_rd_data == TRL);
    assign w_len_bad  = ((fifo_rd_data >> LEN_W) != '0);
    assign w_len_word = fifo_rd_data[LEN_W-1:0];
    assign w_last     = ((r_cnt + LEN_W'(1)) == r_len);
    assign w_ev_first = (r_cnt == '0);
    assign w_pop      = ev_valid && ev_ready;

    // Read only while the buffer plus the in-flight word still fit in two entries
    assign fifo_rd_en = rstn && !fifo_empty && ((3'(r_buf_cnt) + 3'(r_pending)) < 3'd2);

    assign ev_valid   = (r_buf_cnt != 2'd0);
    assign ev_data    = r_buf_data0;
    assign ev_first   = r_buf_first0;
    assign frame_done = r_frame_done;
    assign frame_err  = r_frame_err;
    assign frame_len  = r_frame_len;
    assign err_cnt    = r_err_cnt;
    assign busy       = (r_state != S_IDLE) || (r_buf_cnt != 2'd0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Framing decisions are made only on cycles carrying a freshly read word
    always_comb begin
        w_state_nxt = r_state;
        w_push      = 1'b0;
        w_done      = 1'b0;
        w_err       = 1'b0;
        w_len_ld    = 1'b0;
        w_cnt_inc   = 1'b0;
        if (r_pending) begin
            case (r_state)
                S_IDLE: begin
                    if (w_is_hdr) begin
                        w_state_nxt = S_LEN;
                    end
                end
                S_LEN: begin
                    if (w_is_hdr) begin
                        w_err = 1'b1;
                    end else if (w_is_trl || w_len_bad) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_len_ld    = 1'b1;
                        w_state_nxt = (w_len_word == '0) ? S_TRAIL : S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (w_is_hdr) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_LEN;
                    end else if (w_is_trl) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_push    = 1'b1;
                        w_cnt_inc = 1'b1;
                        if (w_last) begin
                            w_state_nxt = S_TRAIL;
                        end
                    end
                end
                S_TRAIL: begin
                    if (w_is_trl) begin
                        w_done      = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (w_is_hdr) begin
                        w_err       = 1'b1;
                        w_state_nxt = S_LEN;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pending    <= 1'b0;
            r_len        <= '0;
            r_cnt        <= '0;
            r_frame_len  <= '0;
            r_frame_done <= 1'b0;
            r_frame_err  <= 1'b0;
            r_err_cnt    <= 8'd0;
        end else begin
            r_pending    <= fifo_rd_en;
            r_frame_done <= w_done;
            r_frame_err  <= w_err;
            if (w_len_ld) begin
                r_len <= w_len_word;
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + LEN_W'(1);
            end
            if (w_done) begin
                r_frame_len <= r_len;
            end
            if (w_err && (r_err_cnt != 8'hFF)) begin
                r_err_cnt <= r_err_cnt + 8'd1;
            end
        end
    end

    // Two-entry event buffer; entry 0 is always the head
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_buf_cnt    <= 2'd0;
            r_buf_data0  <= '0;
            r_buf_data1  <= '0;
            r_buf_first0 <= 1'b0;
            r_buf_first1 <= 1'b0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_buf_cnt == 2'd0) begin
                        r_buf_data0  <= fifo_rd_data;
                        r_buf_first0 <= w_ev_first;
                    end else begin
                        r_buf_data1  <= fifo_rd_data;
                        r_buf_first1 <= w_ev_first;
                    end
                    r_buf_cnt <= r_buf_cnt + 2'd1;
                end
                2'b01: begin
                    r_buf_data0  <= r_buf_data1;
                    r_buf_first0 <= r_buf_first1;
                    r_buf_cnt    <= r_buf_cnt - 2'd1;
                end
                2'b11: begin
                    if (r_buf_cnt == 2'd1) begin
                        r_buf_data0  <= fifo_rd_data;
                        r_buf_first0 <= w_ev_first;
                    end else begin
                        r_buf_data0  <= r_buf_data1;
                        r_buf_first0 <= r_buf_first1;
                        r_buf_data1  <= fifo_rd_data;
                        r_buf_first1 <= w_ev_first;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_spike_frame_parser.sv
// Bench for spike_frame_parser: directed frames plus random frame streams, checked every
// cycle against a word-stream reference model and a few hand-computed expectations.
module tb_spike_frame_parser;

    localparam int unsigned WIDTH = 16;
    localparam int unsigned LEN_W = 10;
    localparam logic [15:0] HDR = 16'hFAF1;
    localparam logic [15:0] TRL = 16'hF1FA;
    localparam int ST_IDLE  = 0;
    localparam int ST_LEN   = 1;
    localparam int ST_PAY   = 2;
    localparam int ST_TRAIL = 3;

    logic        clk;
    logic        rstn;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [15:0] fifo_rd_data;
    logic        ev_valid;
    logic        ev_ready;
    logic [15:0] ev_data;
    logic        ev_first;
    logic        frame_done;
    logic [9:0]  frame_len;
    logic        frame_err;
    logic [7:0]  err_cnt;
    logic        busy;

    spike_frame_parser #(.WIDTH(WIDTH), .LEN_W(LEN_W)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .fifo_empty   (fifo_empty),
        .fifo_rd_en   (fifo_rd_en),
        .fifo_rd_data (fifo_rd_data),
        .ev_valid     (ev_valid),
        .ev_ready     (ev_ready),
        .ev_data      (ev_data),
        .ev_first     (ev_first),
        .frame_done   (frame_done),
        .frame_len    (frame_len),
        .frame_err    (frame_err),
        .err_cnt      (err_cnt),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    logic [15:0] fq[$];
    logic [16:0] evq[$];
    logic [16:0] obs_ev[$];

    int          m_st;
    int          m_len;
    int          m_cnt;
    bit          m_pending;
    logic [15:0] m_word;
    bit          m_done;
    bit          m_err;
    int          m_flen;
    int          m_errcnt;

    int n_done_obs;
    int n_err_obs;
    int n_valid_obs;
    int n_reads;
    int ready_mode;
    int stall_pct;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic model_reset();
        evq.delete();
        m_st = ST_IDLE; m_len = 0; m_cnt = 0; m_pending = 0; m_word = 16'h0;
        m_done = 0; m_err = 0; m_flen = 0; m_errcnt = 0;
    endtask

    task automatic clear_obs();
        obs_ev.delete();
        n_done_obs = 0; n_err_obs = 0; n_valid_obs = 0; n_reads = 0;
    endtask

    task automatic raise_err();
        m_err = 1;
        if (m_errcnt < 255) m_errcnt++;
    endtask

    // Reference parse of one word: markers take priority, then the per-field meaning
    task automatic parse(input logic [15:0] w);
        bit hdr, trl;
        hdr = (w == HDR);
        trl = (w == TRL);
        if (m_st == ST_IDLE) begin
            if (hdr) m_st = ST_LEN;
        end else if (hdr) begin
            raise_err(); m_st = ST_LEN;
        end else if (trl && m_st != ST_TRAIL) begin
            raise_err(); m_st = ST_IDLE;
        end else if (m_st == ST_TRAIL) begin
            if (trl) begin m_done = 1; m_flen = m_len; end
            else raise_err();
            m_st = ST_IDLE;
        end else if (m_st == ST_LEN) begin
            if (w[15:10] != 6'd0) begin
                raise_err(); m_st = ST_IDLE;
            end else begin
                m_len = int'(w[9:0]); m_cnt = 0;
                m_st  = (m_len == 0) ? ST_TRAIL : ST_PAY;
            end
        end else begin
            evq.push_back({(m_cnt == 0), w});
            m_cnt++;
            if (m_cnt == m_len) m_st = ST_TRAIL;
        end
    endtask

    function automatic logic [15:0] junk_word();
        case ($urandom_range(0, 2))
            0:       return HDR;
            1:       return TRL;
            default: return 16'($urandom);
        endcase
    endfunction

    function automatic logic [15:0] rand_payload();
        logic [15:0] w;
        do w = 16'($urandom); while (w == HDR || w == TRL);
        return w;
    endfunction

    task automatic compare();
        logic exp_rd;
        exp_rd = rstn && !fifo_empty && ((evq.size() + int'(m_pending)) < 2);
        chk("fifo_rd_en", 32'(fifo_rd_en), 32'(exp_rd));
        chk("ev_valid", 32'(ev_valid), 32'(evq.size() != 0));
        if (evq.size() != 0) begin
            chk("ev_data", 32'(ev_data), 32'(evq[0][15:0]));
            chk("ev_first", 32'(ev_first), 32'(evq[0][16]));
        end
        chk("frame_done", 32'(frame_done), 32'(m_done));
        chk("frame_err", 32'(frame_err), 32'(m_err));
        chk("frame_len", 32'(frame_len), 32'(m_flen));
        chk("err_cnt", 32'(err_cnt), 32'(m_errcnt));
        chk("busy", 32'(busy), 32'((m_st != ST_IDLE) || (evq.size() != 0)));
        chk("done_err_excl", 32'(frame_done && frame_err), 32'(0));
    endtask

    // One clock: drive inputs after negedge, check, then advance the model at posedge
    task automatic tick();
        logic rd, pop;
        case (ready_mode)
            0:       ev_ready = 1'b1;
            1:       ev_ready = 1'($urandom_range(0, 1));
            default: ev_ready = 1'b0;
        endcase
        fifo_empty   = (fq.size() == 0) || (int'($urandom_range(0, 99)) < stall_pct);
        fifo_rd_data = m_pending ? m_word : junk_word();
        #1;
        compare();
        rd  = fifo_rd_en;
        pop = ev_valid && ev_ready;
        if (pop) obs_ev.push_back({ev_first, ev_data});
        if (frame_done) n_done_obs++;
        if (frame_err) n_err_obs++;
        if (ev_valid) n_valid_obs++;
        if (rd) n_reads++;
        @(posedge clk);
        if (pop && evq.size() != 0) void'(evq.pop_front());
        m_done = 0;
        m_err  = 0;
        if (m_pending) parse(m_word);
        if (rd && fq.size() != 0) begin
            m_pending = 1;
            m_word    = fq.pop_front();
        end else begin
            m_pending = 0;
        end
        @(negedge clk);
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_rd_en"}, 32'(fifo_rd_en), 32'(0));
        chk({tag, "_ev_valid"}, 32'(ev_valid), 32'(0));
        chk({tag, "_ev_data"}, 32'(ev_data), 32'(0));
        chk({tag, "_ev_first"}, 32'(ev_first), 32'(0));
        chk({tag, "_done"}, 32'(frame_done), 32'(0));
        chk({tag, "_err"}, 32'(frame_err), 32'(0));
        chk({tag, "_len"}, 32'(frame_len), 32'(0));
        chk({tag, "_err_cnt"}, 32'(err_cnt), 32'(0));
        chk({tag, "_busy"}, 32'(busy), 32'(0));
    endtask

    task automatic reset_cycles(input int n);
        rstn = 1'b0;
        model_reset();
        #1;
        check_zero("rst_imm");
        for (int i = 0; i < n; i++) begin
            tick();
            check_zero("rst_hold");
        end
        rstn = 1'b1;
    endtask

    task automatic drain(input int max_cyc);
        int c;
        c = 0;
        while (!(fq.size() == 0 && !m_pending && evq.size() == 0) && c < max_cyc) begin
            tick();
            c++;
        end
        chk("drain_timeout", 32'(c >= max_cyc), 32'(0));
        repeat (3) tick();
    endtask

    task automatic push_words(input logic [15:0] w[$]);
        foreach (w[i]) fq.push_back(w[i]);
    endtask

    task automatic check_events(input string tag, input logic [16:0] e[$]);
        chk({tag, "_count"}, 32'(obs_ev.size()), 32'(e.size()));
        for (int i = 0; i < e.size() && i < obs_ev.size(); i++)
            chk({tag, "_ev"}, 32'(obs_ev[i]), 32'(e[i]));
    endtask

    task automatic gen_item();
        int kind, n;
        kind = int'($urandom_range(0, 9));
        if (kind <= 5) begin
            n = int'($urandom_range(0, 6));
            fq.push_back(HDR); fq.push_back(16'(n));
            repeat (n) fq.push_back(rand_payload());
            fq.push_back(TRL);
        end else if (kind == 6) begin
            fq.push_back(rand_payload());
        end else if (kind == 7) begin
            n = int'($urandom_range(2, 5));
            fq.push_back(HDR); fq.push_back(16'(n));
            repeat (n - 1) fq.push_back(rand_payload());
        end else if (kind == 8) begin
            fq.push_back(HDR); fq.push_back(16'h8000 | 16'($urandom_range(0, 255)));
        end else begin
            fq.push_back(TRL);
            fq.push_back(HDR); fq.push_back(16'h0001);
            fq.push_back(rand_payload()); fq.push_back(rand_payload());
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] words[$];
        logic [16:0] expq[$];
        int c;

        rstn = 1'b0; fifo_empty = 1'b1; fifo_rd_data = 16'h0; ev_ready = 1'b0;
        ready_mode = 0; stall_pct = 0;
        model_reset();
        clear_obs();
        @(negedge clk);
        reset_cycles(3);

        // Basic 3-word frame, downstream always ready
        clear_obs();
        words = '{HDR, 16'h0003, 16'h0011, 16'h0022, 16'h0033, TRL};
        push_words(words);
        drain(200);
        expq = '{17'h10011, 17'h00022, 17'h00033};
        check_events("basic", expq);
        chk("basic_done_pulses", 32'(n_done_obs), 32'(1));
        chk("basic_frame_len", 32'(frame_len), 32'(3));
        chk("basic_err_cnt", 32'(err_cnt), 32'(0));
        chk("basic_err_pulses", 32'(n_err_obs), 32'(0));

        // Same frame with downstream stalled for 10 cycles
        reset_cycles(2);
        clear_obs();
        push_words(words);
        ready_mode = 2;
        repeat (10) tick();
        chk("stall_reads", 32'(n_reads), 32'(4));
        chk("stall_ev_data", 32'(ev_data), 32'(16'h0011));
        chk("stall_ev_valid", 32'(ev_valid), 32'(1));
        ready_mode = 0;
        drain(200);
        check_events("stall", expq);
        chk("stall_done_pulses", 32'(n_done_obs), 32'(1));
        chk("stall_frame_len", 32'(frame_len), 32'(3));

        // Trailer arrives early
        reset_cycles(2);
        clear_obs();
        words = '{HDR, 16'h0004, 16'h0011, TRL};
        push_words(words);
        drain(200);
        expq = '{17'h10011};
        check_events("short", expq);
        chk("short_err_pulses", 32'(n_err_obs), 32'(1));
        chk("short_err_cnt", 32'(err_cnt), 32'(1));
        chk("short_done_pulses", 32'(n_done_obs), 32'(0));

        // Header mid-payload resyncs into a new frame
        reset_cycles(2);
        clear_obs();
        words = '{HDR, 16'h0002, 16'h0011, HDR, 16'h0001, 16'h0055, TRL};
        push_words(words);
        drain(200);
        expq = '{17'h10011, 17'h10055};
        check_events("resync", expq);
        chk("resync_err_cnt", 32'(err_cnt), 32'(1));
        chk("resync_err_pulses", 32'(n_err_obs), 32'(1));
        chk("resync_done_pulses", 32'(n_done_obs), 32'(1));
        chk("resync_frame_len", 32'(frame_len), 32'(1));

        // Empty frame preceded by stray words
        reset_cycles(2);
        clear_obs();
        words = '{16'h1234, 16'h1234, HDR, 16'h0000, TRL};
        push_words(words);
        drain(200);
        chk("empty_done_pulses", 32'(n_done_obs), 32'(1));
        chk("empty_frame_len", 32'(frame_len), 32'(0));
        chk("empty_valid_cycles", 32'(n_valid_obs), 32'(0));
        chk("empty_err_cnt", 32'(err_cnt), 32'(0));

        // Reset in the middle of a frame, then a clean frame
        reset_cycles(2);
        clear_obs();
        words = '{HDR, 16'h0003, 16'h0011, 16'h0022, 16'h0033, TRL};
        push_words(words);
        c = 0;
        while (evq.size() == 0 && c < 20) begin tick(); c++; end
        chk("midrst_reached", 32'(c < 20), 32'(1));
        reset_cycles(3);
        clear_obs();
        words = '{HDR, 16'h0002, 16'h00AA, 16'h00BB, TRL};
        push_words(words);
        drain(300);
        expq = '{17'h100AA, 17'h000BB};
        check_events("midrst", expq);
        chk("midrst_err_cnt", 32'(err_cnt), 32'(0));
        chk("midrst_frame_len", 32'(frame_len), 32'(2));
        chk("midrst_done_pulses", 32'(n_done_obs), 32'(1));

        // Error counter saturation
        reset_cycles(2);
        clear_obs();
        repeat (260) begin fq.push_back(HDR); fq.push_back(TRL); end
        drain(3000);
        chk("sat_err_cnt", 32'(err_cnt), 32'(255));
        chk("sat_err_pulses", 32'(n_err_obs), 32'(260));

        // Random frame streams with random backpressure and FIFO stalls
        reset_cycles(2);
        clear_obs();
        ready_mode = 1;
        stall_pct  = 0;
        repeat (60) gen_item();
        drain(20000);
        stall_pct = 30;
        repeat (60) gen_item();
        drain(20000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
